// File: rtl/reg_dump_reader.sv
// Streams a contiguous range of register-bank entries, one valid/ready beat per
// register, reading through the bank's spare combinational read port.
module reg_dump_reader #(
  parameter int SKIP_ZERO = 0
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [4:0]  iFirst,
  input  logic [4:0]  iLast,
  output logic [4:0]  oRs,
  input  logic [31:0] iRegData,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oData,
  output logic [4:0]  oIndex,
  output logic        oLast,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  first_q, first_d;
  logic [4:0]  last_q, last_d;
  logic [4:0]  index_q, index_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        lastb_q, lastb_d;
  logic [4:0]  start_idx;

  // x0 is hardwired zero in most banks, so the dump can optionally begin at x1.
  assign start_idx = ((SKIP_ZERO != 0) && (iFirst == 5'd0)) ? 5'd1 : iFirst;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 5'd0;
      first_q <= 5'd0;
      last_q  <= 5'd0;
      index_q <= 5'd0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      lastb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      last_q  <= last_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lastb_q <= lastb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    last_d  = last_q;
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    lastb_d = lastb_q;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          first_d = start_idx;
          last_d  = iLast;
          ptr_d   = start_idx;
          state_d = (start_idx <= iLast) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        // Capture happens at the edge, so a same-edge bank write is not seen.
        data_d  = iRegData;
        index_d = ptr_q;
        lastb_d = (ptr_q == last_q);
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (iReady) begin
          valid_d = 1'b0;
          lastb_d = 1'b0;
          if (ptr_q == last_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + 5'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything else, including a same-cycle handshake.
    if ((state_q != S_IDLE) && iAbort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      lastb_d = 1'b0;
    end
  end

  assign oRs    = ((state_q == S_READ) || (state_q == S_HOLD)) ? ptr_q : 5'd0;
  assign oValid = valid_q;
  assign oData  = data_q;
  assign oIndex = index_q;
  assign oLast  = lastb_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a behavioural register bank feeds two
// instances (SKIP_ZERO=0 and SKIP_ZERO=1) sharing most of their inputs.
module tb_reg_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start0, start1, abort, ready;
  logic [4:0]  f_in, l_in;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] bank [32];

  logic [4:0]  rs0, rs1, idx0, idx1;
  logic [31:0] rd0, rd1, d0, d1;
  logic        v0, v1, lst0, lst1, busy0, busy1, done0, done1;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0]  bq_idx[$];
  logic [31:0] bq_data[$];
  logic        bq_last[$];
  int          dc;

  assign rd0 = bank[rs0];
  assign rd1 = bank[rs1];

  always @(posedge clk) if (we) bank[wa] <= wd;

  reg_dump_reader #(.SKIP_ZERO(0)) dut0 (
    .iCLK(clk), .iRST_n(rst_n), .iStart(start0), .iAbort(abort),
    .iFirst(f_in), .iLast(l_in), .oRs(rs0), .iRegData(rd0),
    .oValid(v0), .iReady(ready), .oData(d0), .oIndex(idx0),
    .oLast(lst0), .oBusy(busy0), .oDone(done0)
  );

  reg_dump_reader #(.SKIP_ZERO(1)) dut1 (
    .iCLK(clk), .iRST_n(rst_n), .iStart(start1), .iAbort(abort),
    .iFirst(f_in), .iLast(l_in), .oRs(rs1), .iRegData(rd1),
    .oValid(v1), .iReady(ready), .oData(d1), .oIndex(idx1),
    .oLast(lst1), .oBusy(busy1), .oDone(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Returns #1 after the edge that samples iStart (cycle 1 of the dump).
  task automatic start_pulse(input bit sel, input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    f_in = f; l_in = l;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Runs a dump, recording accepted beats; done_cyc is the cycle oDone is seen.
  task automatic dump(input bit sel, input logic [4:0] f, input logic [4:0] l,
                      input int budget, output int done_cyc);
    bq_idx.delete(); bq_data.delete(); bq_last.delete();
    done_cyc = -1;
    start_pulse(sel, f, l);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if ((sel ? v1 : v0) && ready) begin
        bq_idx.push_back(sel ? idx1 : idx0);
        bq_data.push_back(sel ? d1 : d0);
        bq_last.push_back(sel ? lst1 : lst0);
      end
      if (sel ? done1 : done0) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b1;
    f_in = 5'd0; l_in = 5'd0; we = 1'b0; wa = 5'd0; wd = 32'd0;
    #3 rst_n = 1'b0;

    // Preset the bank while in reset: x2=1020, x11=16, others 0.
    we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wa = 5'(i);
      wd = (i == 2) ? 32'd1020 : (i == 11) ? 32'd16 : 32'd0;
      @(posedge clk); #1;
    end
    we = 1'b0;

    check("rst_valid", {31'd0, v0}, 32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_data",  d0, 32'd0);
    check("rst_index", {27'd0, idx0}, 32'd0);
    check("rst_rs",    {27'd0, rs0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full 0..31 dump with ready held high.
    dump(1'b0, 5'd0, 5'd31, 80, dc);
    check("full_cycles", dc, 32'd65);
    check("full_beats", bq_idx.size(), 32'd32);
    if (bq_idx.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        check($sformatf("full_idx%0d", i), {27'd0, bq_idx[i]}, i);
        check($sformatf("full_data%0d", i), bq_data[i],
              (i == 2) ? 32'd1020 : (i == 11) ? 32'd16 : 32'd0);
        check($sformatf("full_last%0d", i), {31'd0, bq_last[i]}, (i == 31) ? 32'd1 : 32'd0);
      end
    end
    @(posedge clk); @(negedge clk);
    check("full_after_busy", {31'd0, busy0}, 32'd0);
    check("full_after_done", {31'd0, done0}, 32'd0);
    check("full_after_rs", {27'd0, rs0}, 32'd0);

    // Backpressure on a single-register dump of x2.
    ready = 1'b0;
    start_pulse(1'b0, 5'd2, 5'd2);
    @(negedge clk);
    check("bp_read_valid", {31'd0, v0}, 32'd0);
    check("bp_read_rs", {27'd0, rs0}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("bp_hold%0d_valid", i), {31'd0, v0}, 32'd1);
      check($sformatf("bp_hold%0d_data", i), d0, 32'd1020);
      check($sformatf("bp_hold%0d_index", i), {27'd0, idx0}, 32'd2);
      check($sformatf("bp_hold%0d_last", i), {31'd0, lst0}, 32'd1);
    end
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", {31'd0, v0}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("bp_done", {31'd0, done0}, 32'd1);
    check("bp_done_valid", {31'd0, v0}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("bp_idle_busy", {31'd0, busy0}, 32'd0);

    // Empty range F>L.
    start_pulse(1'b0, 5'd5, 5'd3);
    @(negedge clk);
    check("empty_done", {31'd0, done0}, 32'd1);
    check("empty_busy", {31'd0, busy0}, 32'd1);
    check("empty_valid", {31'd0, v0}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("empty_done_off", {31'd0, done0}, 32'd0);
    check("empty_busy_off", {31'd0, busy0}, 32'd0);

    // Empty range through SKIP_ZERO (0..0 becomes 1..0).
    start_pulse(1'b1, 5'd0, 5'd0);
    @(negedge clk);
    check("skip_empty_done", {31'd0, done1}, 32'd1);
    check("skip_empty_busy", {31'd0, busy1}, 32'd1);
    check("skip_empty_valid", {31'd0, v1}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("skip_empty_busy_off", {31'd0, busy1}, 32'd0);

    // SKIP_ZERO dump of 0..3 yields only x1..x3.
    dump(1'b1, 5'd0, 5'd3, 20, dc);
    check("skip_cycles", dc, 32'd7);
    check("skip_beats", bq_idx.size(), 32'd3);
    if (bq_idx.size() == 3) begin
      check("skip_idx0", {27'd0, bq_idx[0]}, 32'd1);
      check("skip_idx1", {27'd0, bq_idx[1]}, 32'd2);
      check("skip_data1", bq_data[1], 32'd1020);
      check("skip_last2", {31'd0, bq_last[2]}, 32'd1);
    end

    // Abort during HOLD of index 4, with ready also high.
    start_pulse(1'b0, 5'd0, 5'd31);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_pre_index", {27'd0, idx0}, 32'd4);
    check("abort_pre_valid", {31'd0, v0}, 32'd1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_valid", {31'd0, v0}, 32'd0);
    check("abort_last", {31'd0, lst0}, 32'd0);
    check("abort_done", {31'd0, done0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("abort_nodone%0d", i), {31'd0, done0 | busy0}, 32'd0);
    end

    // Reset asserted asynchronously during READ of index 3.
    start_pulse(1'b0, 5'd0, 5'd31);
    repeat (6) @(posedge clk);
    #2;
    check("rstmid_pre_index", {27'd0, idx0}, 32'd2);
    check("rstmid_pre_rs", {27'd0, rs0}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, busy0}, 32'd0);
    check("rstmid_data", d0, 32'd0);
    check("rstmid_index", {27'd0, idx0}, 32'd0);
    check("rstmid_rs", {27'd0, rs0}, 32'd0);
    check("rstmid_flags", {29'd0, v0, lst0, done0}, 32'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rstmid_wait_idle", {31'd0, busy0}, 32'd0);
    dump(1'b0, 5'd2, 5'd3, 20, dc);
    check("rstmid_redump_cycles", dc, 32'd5);
    check("rstmid_redump_beats", bq_idx.size(), 32'd2);
    if (bq_idx.size() == 2) begin
      check("rstmid_redump_idx0", {27'd0, bq_idx[0]}, 32'd2);
      check("rstmid_redump_data0", bq_data[0], 32'd1020);
      check("rstmid_redump_last1", {31'd0, bq_last[1]}, 32'd1);
    end

    // Write collision on x5 at the READ capture edge.
    @(posedge clk); #1 we = 1'b1; wa = 5'd5; wd = 32'd7;
    @(posedge clk); #1 we = 1'b0;
    start_pulse(1'b0, 5'd5, 5'd5);
    we = 1'b1; wa = 5'd5; wd = 32'd99;
    @(posedge clk); #1 we = 1'b0;
    @(negedge clk);
    check("coll_valid", {31'd0, v0}, 32'd1);
    check("coll_data", d0, 32'd7);
    check("coll_index", {27'd0, idx0}, 32'd5);
    @(posedge clk); @(negedge clk);
    check("coll_done", {31'd0, done0}, 32'd1);
    dump(1'b0, 5'd5, 5'd5, 10, dc);
    check("coll2_cycles", dc, 32'd3);
    check("coll2_beats", bq_idx.size(), 32'd1);
    if (bq_idx.size() == 1) check("coll2_data", bq_data[0], 32'd99);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
